// File: rtl/io_mmu_l15_responder.sv
// io_mmu_l15_responder: L1.5-style responder backed by a small page-table
// memory. It serves loads and stores in a fixed-latency window, captures
// interrupt packets for a consumer, and exposes a backdoor write port.

`ifndef L15_PADDR_HI
`define L15_PADDR_HI 39
`endif

module io_mmu_l15_responder #(
  parameter int unsigned              MEM_WORDS = 64,
  parameter int unsigned              LATENCY   = 2,
  parameter logic [`L15_PADDR_HI:0]   BASE_ADDR = 40'h0080004000,
  localparam int unsigned             IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // bus request / response
  input  logic                        l15_val,
  input  logic                        l15_store,
  input  logic                        l15_interrupt,
  input  logic [`L15_PADDR_HI:0]      l15_address,
  input  logic [63:0]                 l15_data,
  output logic                        l15_ack,
  output logic                        l15_rvalid,
  output logic [63:0]                 l15_rdata,
  // backdoor memory write
  input  logic                        bd_we_i,
  input  logic [IDX_W-1:0]            bd_idx_i,
  input  logic [63:0]                 bd_data_i,
  // interrupt packet hand-off
  output logic                        irq_val_o,
  output logic [63:0]                 irq_data_o,
  input  logic                        irq_ack_i,
  // status
  output logic                        err_o,
  output logic                        busy_o
);

  localparam int unsigned PH     = `L15_PADDR_HI;
  localparam int unsigned TAG_LO = IDX_W + 3;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             store_q, store_d;
  logic [PH:0]      addr_q, addr_d;
  logic             irq_val_q, irq_val_d;
  logic [63:0]      irq_data_q, irq_data_d;
  logic             err_q, err_d;
  logic [63:0]      mem_q [MEM_WORDS];
  logic [63:0]      mem_d [MEM_WORDS];

  logic             accept;

  // Tag bits must match the window base and the address must be word aligned.
  function automatic logic in_window(input logic [PH:0] a);
    return (a[PH:TAG_LO] == BASE_ADDR[PH:TAG_LO]) && (a[2:0] == 3'b000);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [PH:0] a);
    return a[IDX_W+2:3];
  endfunction

  // A pending interrupt back-pressures only further interrupt stores; ack is
  // forced low while reset is asserted.
  assign accept = rst_ni && (state_q == IDLE) && l15_val &&
                  !(l15_store && l15_interrupt && irq_val_q);

  // Request FSM: accept, count down the latency, respond for one cycle.
  // Store data and the interrupt flag are consumed on the accept edge, so only
  // the fields the response still needs are held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          store_d = l15_store;
          addr_d  = l15_address;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory writes, interrupt capture and the sticky error flag.
  always_comb begin
    mem_d      = mem_q;
    irq_val_d  = irq_val_q;
    irq_data_d = irq_data_q;
    err_d      = err_q;

    if (irq_ack_i) begin
      irq_val_d = 1'b0;
    end

    if (accept) begin
      if (l15_store && l15_interrupt) begin
        irq_val_d  = 1'b1;
        irq_data_d = l15_data;
      end else if (!in_window(l15_address)) begin
        err_d = 1'b1;
      end else if (l15_store) begin
        mem_d[word_idx(l15_address)] = l15_data;
      end
    end

    // Applied last so the backdoor wins a same-index collision.
    if (bd_we_i) begin
      mem_d[bd_idx_i] = bd_data_i;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      store_q    <= 1'b0;
      addr_q     <= '0;
      irq_val_q  <= 1'b0;
      irq_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      store_q    <= store_d;
      addr_q     <= addr_d;
      irq_val_q  <= irq_val_d;
      irq_data_q <= irq_data_d;
      err_q      <= err_d;
    end
  end

  // Page-table storage, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign l15_ack    = accept;
  assign l15_rvalid = (state_q == RESP);
  assign l15_rdata  = (l15_rvalid && !store_q && in_window(addr_q)) ?
                      mem_q[word_idx(addr_q)] : '0;
  assign irq_val_o  = irq_val_q;
  assign irq_data_o = irq_data_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);

endmodule
